// File: rtl/prog_instruction_memory.sv
// ============================================================================
// Module   : prog_instruction_memory
// Brief    : Run-time loadable instruction memory with a registered fetch port,
//            valid/stall handshake and a streaming load port. Define the macro
//            IMEM_ALIGN_CHECK_EN to flag misaligned fetches on addr_fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_instruction_memory #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'hE1A00000)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          address,
    input  logic                       stall,
    output logic [DATA_W-1:0]          instruction,
    output logic                       instr_valid,
    input  logic                       load_start,
    input  logic [$clog2(DEPTH):0]     load_len,
    input  logic                       load_valid,
    input  logic [DATA_W-1:0]          load_data,
    output logic                       load_ready,
    output logic                       load_done,
    output logic                       busy,
    output logic                       addr_fault
);

    localparam int                c_IDX_W = $clog2(DEPTH);
    localparam int                c_LEN_W = c_IDX_W + 1;
    localparam logic [c_LEN_W-1:0] c_LEN_MAX = c_LEN_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  c_DEPTH_A = ADDR_W'(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_LEN_W-1:0] r_wptr;
    logic [c_LEN_W-1:0] r_len;
    logic [DATA_W-1:0]  r_instruction;
    logic               r_valid;
    logic               r_done;
    logic               r_fault;

    logic [c_LEN_W-1:0] w_len_clamped;
    logic               w_write;
    logic               w_last;
    logic [ADDR_W-1:0]  w_word;
    logic               w_out_of_range;
    logic               w_misalign;

    assign w_len_clamped  = (load_len > c_LEN_MAX) ? c_LEN_MAX : load_len;
    assign w_write        = (r_state == c_LOAD) && load_valid && !load_start;
    assign w_last         = (r_wptr + c_LEN_W'(1)) == r_len;
    assign w_word         = {2'b00, address[ADDR_W-1:2]};
    assign w_out_of_range = w_word >= c_DEPTH_A;

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_misalign = |address[1:0];
`else
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, address[1:0]};
    assign w_misalign    = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; load_start overrides every state
    always_comb begin
        w_state_next = r_state;
        if (load_start) begin
            w_state_next = (w_len_clamped == '0) ? c_RUN : c_LOAD;
        end else begin
            case (r_state)
                c_LOAD:  if (w_write && w_last) w_state_next = c_RUN;
                c_RUN:   w_state_next = c_RUN;
                default: w_state_next = c_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        load_ready = 1'b0;
        busy       = 1'b1;
        case (r_state)
            c_LOAD:  load_ready = 1'b1;
            c_RUN:   busy       = 1'b0;
            default: ;
        endcase
    end

    // Load pointer, length latch and completion pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr <= '0;
            r_len  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (load_start && (w_len_clamped == '0)) || (w_write && w_last);
            if (load_start) begin
                r_wptr <= '0;
                r_len  <= w_len_clamped;
            end else if (w_write) begin
                r_wptr <= r_wptr + c_LEN_W'(1);
            end
        end
    end

    // Storage is never cleared by reset
    always_ff @(posedge clock) begin
        if (w_write && !reset) begin
            r_mem[r_wptr[c_IDX_W-1:0]] <= load_data;
        end
    end

    // Registered fetch; stall freezes every output of this port
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instruction <= NOP_WORD;
            r_valid       <= 1'b0;
            r_fault       <= 1'b0;
        end else if (load_start || (r_state != c_RUN)) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (fetch_req) begin
                r_valid <= 1'b1;
                r_fault <= w_misalign;
                if (w_out_of_range || w_misalign) begin
                    r_instruction <= NOP_WORD;
                end else begin
                    r_instruction <= r_mem[w_word[c_IDX_W-1:0]];
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign instruction = r_instruction;
    assign instr_valid = r_valid;
    assign load_done   = r_done;
    assign addr_fault  = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_prog_instruction_memory.sv
// ============================================================================
// Module   : tb_prog_instruction_memory
// Brief    : Directed self-checking bench for prog_instruction_memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_instruction_memory;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam logic [31:0] c_NOP = 32'hE1A00000;
    localparam logic [31:0] c_W0  = 32'hE3A00014;
    localparam logic [31:0] c_W1  = 32'hE3A01A01;
    localparam logic [31:0] c_W2  = 32'hE3A02103;
    localparam logic [31:0] c_A   = 32'h11110000;
    localparam logic [31:0] c_B   = 32'h22220004;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              stall = 1'b0;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              load_start = 1'b0;
    logic [10:0]       load_len = '0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_ready;
    logic              load_done;
    logic              busy;
    logic              addr_fault;

    int r_tests = 0;
    int r_fails = 0;

    prog_instruction_memory #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(c_NOP)
    ) dut (
        .clock(clock), .reset(reset), .fetch_req(fetch_req), .address(address),
        .stall(stall), .instruction(instruction), .instr_valid(instr_valid),
        .load_start(load_start), .load_len(load_len), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
        .busy(busy), .addr_fault(addr_fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
        fetch_req = 1'b1;
        address   = a;
        tick();
        check({tag, "_instr"}, instruction, exp);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_instr", instruction, c_NOP);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_ready", 32'(load_ready), 0);
        check("rst_done", 32'(load_done), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_fault", 32'(addr_fault), 0);
        reset = 1'b0;

        // Load three words
        load_start = 1'b1;
        load_len   = 11'd3;
        tick();
        load_start = 1'b0;
        check("ld_ready0", 32'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = c_W0;
        tick();
        check("ld_ready1", 32'(load_ready), 1);
        check("ld_nodone1", 32'(load_done), 0);
        load_data = c_W1;
        tick();
        check("ld_ready2", 32'(load_ready), 1);
        load_data = c_W2;
        tick();
        load_valid = 1'b0;
        check("ld_done", 32'(load_done), 1);
        check("ld_ready_off", 32'(load_ready), 0);
        check("ld_busy_off", 32'(busy), 0);
        tick();
        check("ld_done_pulse", 32'(load_done), 0);

        // Back-to-back fetch
        fetch(32'd0, c_W0, "f0");
        fetch(32'd4, c_W1, "f4");
        fetch(32'd8, c_W2, "f8");

        // Stall holds output
        stall   = 1'b1;
        address = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_instr", instruction, c_W2);
            check("stall_valid", 32'(instr_valid), 1);
        end
        stall = 1'b0;
        tick();
        check("unstall_instr", instruction, c_W0);

        // Out of range, then idle fetch port holds the word
        fetch(32'd4096, c_NOP, "oor");
        fetch(32'd4, c_W1, "f4b");
        fetch_req = 1'b0;
        tick();
        check("nofetch_valid", 32'(instr_valid), 0);
        check("nofetch_hold", instruction, c_W1);

        // load_start in RUN clears valid, fetches ignored during LOAD
        fetch(32'd0, c_W0, "prel");
        fetch_req  = 1'b0;
        load_start = 1'b1;
        load_len   = 11'd5;
        tick();
        load_start = 1'b0;
        check("ls_valid", 32'(instr_valid), 0);
        check("ls_busy", 32'(busy), 1);
        fetch_req  = 1'b1;
        address    = 32'd0;
        load_valid = 1'b1;
        load_data  = c_A;
        tick();
        check("load_fetch_valid", 32'(instr_valid), 0);
        load_data = c_B;
        tick();
        check("load_fetch_valid2", 32'(instr_valid), 0);
        load_valid = 1'b0;

        // Reset mid-load
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 1);
        check("mid_rst_ready", 32'(load_ready), 0);
        check("mid_rst_done", 32'(load_done), 0);
        tick();
        check("idle_fetch_valid", 32'(instr_valid), 0);
        check("idle_done", 32'(load_done), 0);

        // Zero-length reload
        fetch_req  = 1'b0;
        load_start = 1'b1;
        load_len   = 11'd0;
        tick();
        load_start = 1'b0;
        check("len0_done", 32'(load_done), 1);
        check("len0_busy", 32'(busy), 0);
        fetch(32'd0, c_A, "ret0");
        check("len0_pulse", 32'(load_done), 0);
        fetch(32'd4, c_B, "ret1");
        fetch(32'd8, c_W2, "ret2");

`ifdef IMEM_ALIGN_CHECK_EN
        fetch(32'd6, c_NOP, "mis");
        check("mis_fault", 32'(addr_fault), 1);
        stall = 1'b1;
        tick();
        check("mis_fault_hold", 32'(addr_fault), 1);
        stall = 1'b0;
        fetch(32'd4, c_B, "al");
        check("al_fault", 32'(addr_fault), 0);
`else
        fetch(32'd6, c_B, "mis");
        check("mis_fault", 32'(addr_fault), 0);
`endif

        // Oversized length clamps to DEPTH
        fetch_req  = 1'b0;
        load_start = 1'b1;
        load_len   = 11'd2000;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            load_data = 32'hA5000000 + 32'(i);
            tick();
        end
        load_valid = 1'b0;
        check("clamp_done", 32'(load_done), 1);
        check("clamp_busy", 32'(busy), 0);
        fetch(32'd4092, 32'hA50003FF, "clamp_last");
        fetch(32'd0, 32'hA5000000, "clamp_first");

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_instruction_memory.md
Name: prog_instruction_memory

Overview:
Parametrised, loadable successor to the hard-wired instruction ROM that feeds the ARM-subset fetch stage.
- Word storage of configurable depth and width, filled at run time through a streaming load port instead of fixed contents.
- Registered (1-cycle) fetch with valid/stall handshake so the pipeline can freeze IF.
- Byte-addressed fetch; word index = address >> 2.

Parameters:
DATA_W, 32, instruction word width
DEPTH, 1024, number of words stored
ADDR_W, 32, fetch byte-address width
NOP_WORD, 32'hE1A00000, word returned for out-of-range fetches (MOV R0,R0)

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
fetch_req  in  1  request a fetch at address this cycle
address  in  ADDR_W  byte address of requested instruction
stall  in  1  hold current fetch output; no new fetch accepted
instruction  out  DATA_W  fetched word
instr_valid  out  1  instruction is valid
load_start  in  1  begin (re)loading program memory
load_len  in  $clog2(DEPTH)+1  number of words to load, sampled with load_start
load_valid  in  1  load_data valid
load_data  in  DATA_W  program word
load_ready  out  1  memory accepts a load word this cycle
load_done  out  1  one-cycle pulse, load complete
busy  out  1  high in IDLE or LOAD (fetch not serviced)
addr_fault  out  1  misaligned fetch flag (see Optional Feature)

Behaviour:
- Reset values: instruction=NOP_WORD, instr_valid=0, load_ready=0, load_done=0, busy=1, addr_fault=0, state=IDLE, write pointer=0.
- Reset does not clear the storage array.
- States: IDLE, LOAD, RUN.
  - IDLE: wait for load_start, then go to LOAD.
  - LOAD:
    - load_ready=1.
    - Each cycle with load_valid&&load_ready writes mem[wptr]=load_data and increments wptr.
    - After the load_len-th word is written: go to RUN and pulse load_done in the cycle after the last write.
  - RUN: fetch serviced; load_start returns to LOAD.
- load_start in any state:
  - Latches load_len and sets wptr=0.
  - Enters LOAD next cycle and clears instr_valid next cycle.
- load_len=0: the cycle after load_start goes straight to RUN with a load_done pulse; no writes.
- load_len>DEPTH: clamped to DEPTH.
- Load with load_valid low stalls the load indefinitely; there is no timeout.
- Fetch, RUN only:
  - fetch_req&&!stall at cycle N → cycle N+1: instruction=mem[address>>2], instr_valid=1.
  - If the word index ≥ DEPTH: instruction=NOP_WORD, instr_valid=1.
- stall=1: instruction, instr_valid and addr_fault hold exactly; fetch_req ignored.
- fetch_req=0&&stall=0: instr_valid→0 next cycle; instruction holds its last value.
- fetch_req in IDLE/LOAD: ignored; instr_valid stays 0.
- Read/write collision: writes occur only in LOAD, fetches only in RUN, so no same-cycle conflict exists.
- Reset mid-load:
  - Goes to IDLE with wptr=0.
  - Words already written are retained.
  - load_done is not pulsed.

Optional Feature:
Macro IMEM_ALIGN_CHECK_EN.
- Defined: an accepted fetch with address[1:0]≠0 gives, next cycle, instruction=NOP_WORD, instr_valid=1, addr_fault=1. Any aligned accepted fetch clears addr_fault. addr_fault holds under stall.
- Undefined: address[1:0] is ignored (word index = address>>2) and addr_fault is tied to 0.

Test Plan:
1. Reset, load_start with load_len=3, stream 0xE3A00014, 0xE3A01A01, 0xE3A02103 with load_valid=1 continuously → load_ready high 3 cycles, load_done pulses once, busy=0. Then fetch 0, 4, 8 back-to-back → instruction equals those words on cycles N+1..N+3, instr_valid=1.
2. In RUN, fetch address 8 then assert stall for 4 cycles with fetch_req=1 and address=0 → instruction stays 0xE3A02103, instr_valid=1 throughout; after stall drops, next word is mem[0].
3. Fetch address 4*DEPTH (4096) → instruction=0xE1A00000, instr_valid=1.
4. load_start with load_len=5, reset after 2 words → state IDLE, busy=1, no load_done. Then reload with load_len=0 → load_done pulse next cycle, RUN, mem[0..1] still readable.
5. Fetch in IDLE and in LOAD → instr_valid remains 0. load_start during RUN with a valid output → instr_valid=0 next cycle.
6. With IMEM_ALIGN_CHECK_EN, fetch address 0x6 → addr_fault=1, instruction=NOP_WORD; next fetch at 0x4 → addr_fault=0. Without the macro, fetch 0x6 returns mem[1] and addr_fault=0.
